// File: rtl/bip_control_pkg.sv
// Shared definitions for the BIP control unit and its datapath: opcode
// values, FSM state encoding and accumulator/ALU mux select encodings.
package bip_control_pkg;

  localparam int OPCODE_W = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_HLT  = 5'b00000;
  localparam opcode_t OP_STO  = 5'b00001;
  localparam opcode_t OP_LD   = 5'b00010;
  localparam opcode_t OP_LDI  = 5'b00011;
  localparam opcode_t OP_ADD  = 5'b00100;
  localparam opcode_t OP_ADDI = 5'b00101;
  localparam opcode_t OP_SUB  = 5'b00110;
  localparam opcode_t OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // ALU B operand source select
  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_EXT = 1'b1;

  // ALU operation
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  function automatic logic is_halt(input opcode_t opc);
    return (opc == OP_HLT);
  endfunction

endpackage

// File: rtl/bip_control_if.sv
// Control bus between the sequencer and the opcode decoder: the sequencer
// supplies the current opcode and an execute qualifier, the decoder returns
// the datapath strobes and mux selects.
interface bip_control_if;
  import bip_control_pkg::*;

  opcode_t    opcode;
  logic       exec;
  logic [1:0] sel_a;
  logic       sel_b;
  logic       wr_acc;
  logic       op;
  logic       wr_ram;
  logic       rd_ram;

  modport master (
    output opcode, exec,
    input  sel_a, sel_b, wr_acc, op, wr_ram, rd_ram
  );

  modport slave (
    input  opcode, exec,
    output sel_a, sel_b, wr_acc, op, wr_ram, rd_ram
  );

endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control decode. Everything is forced to the
// neutral value unless exec is high, so the strobes can only appear during
// an enabled execute cycle.
module bip_decoder
  import bip_control_pkg::*;
(
  bip_control_if.slave ctl
);

  // Opcode decode, qualified by exec; unlisted opcodes behave as NOP
  always_comb begin
    ctl.sel_a  = SEL_A_MEM;
    ctl.sel_b  = SEL_B_MEM;
    ctl.op     = ALU_ADD;
    ctl.wr_acc = 1'b0;
    ctl.wr_ram = 1'b0;
    ctl.rd_ram = 1'b0;
    if (ctl.exec) begin
      case (ctl.opcode)
        OP_STO: begin
          ctl.wr_ram = 1'b1;
        end
        OP_LD: begin
          ctl.rd_ram = 1'b1;
          ctl.wr_acc = 1'b1;
          ctl.sel_a  = SEL_A_MEM;
        end
        OP_LDI: begin
          ctl.wr_acc = 1'b1;
          ctl.sel_a  = SEL_A_EXT;
        end
        OP_ADD: begin
          ctl.rd_ram = 1'b1;
          ctl.wr_acc = 1'b1;
          ctl.sel_a  = SEL_A_ALU;
          ctl.sel_b  = SEL_B_MEM;
          ctl.op     = ALU_ADD;
        end
        OP_ADDI: begin
          ctl.wr_acc = 1'b1;
          ctl.sel_a  = SEL_A_ALU;
          ctl.sel_b  = SEL_B_EXT;
          ctl.op     = ALU_ADD;
        end
        OP_SUB: begin
          ctl.rd_ram = 1'b1;
          ctl.wr_acc = 1'b1;
          ctl.sel_a  = SEL_A_ALU;
          ctl.sel_b  = SEL_B_MEM;
          ctl.op     = ALU_SUB;
        end
        OP_SUBI: begin
          ctl.wr_acc = 1'b1;
          ctl.sel_a  = SEL_A_ALU;
          ctl.sel_b  = SEL_B_EXT;
          ctl.op     = ALU_SUB;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: IDLE/FETCH/DECODE/EXEC/HALT sequencer with program
// counter, instruction register and retired-instruction counter. Program
// memory has one cycle of read latency, so the address is presented in
// FETCH and the instruction is captured at the end of DECODE.
module bip_control
  import bip_control_pkg::*;
#(
  parameter int NBITS_PC     = 11,
  parameter int NBITS_OPCODE = 5,
  parameter int NBITS_I      = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NBITS_I-1:0]  i_Instruction,
  output logic [NBITS_PC-1:0] o_Addr_PC,
  output logic [NBITS_PC-1:0] o_Operand,
  output logic [1:0]          o_SelA,
  output logic                o_SelB,
  output logic                o_WrAcc,
  output logic                o_Op,
  output logic                o_WrRam,
  output logic                o_RdRam,
  output logic                o_Halt,
  output logic [15:0]         o_InstrCount
);

  state_t              state_reg, state_next;
  logic [NBITS_PC-1:0] pc_reg, pc_next;
  logic [NBITS_I-1:0]  ir_reg, ir_next;
  logic [15:0]         count_reg, count_next;
  opcode_t             ir_opcode;

  bip_control_if ctl_bus ();

  bip_decoder u_decoder (
    .ctl (ctl_bus.slave)
  );

  assign ir_opcode      = ir_reg[NBITS_I-1 -: NBITS_OPCODE];
  assign ctl_bus.opcode = ir_opcode;
  // Strobes only in an enabled EXEC cycle, and never while reset is applied
  assign ctl_bus.exec   = (state_reg == EXEC) && i_enable && !i_reset;

  // Next-state, PC, IR and counter update; nothing moves while disabled
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    count_next = count_reg;
    if (i_enable) begin
      case (state_reg)
        IDLE:   state_next = FETCH;
        FETCH:  state_next = DECODE;
        DECODE: begin
          state_next = EXEC;
          ir_next    = i_Instruction;
        end
        EXEC: begin
          count_next = count_reg + 16'd1;
          if (is_halt(ir_opcode)) begin
            state_next = HALT;
          end else begin
            state_next = FETCH;
            pc_next    = pc_reg + 1'b1;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // State and architectural registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      count_reg <= count_next;
    end
  end

  assign o_Addr_PC    = pc_reg;
  assign o_Operand    = ir_reg[NBITS_PC-1:0];
  assign o_SelA       = ctl_bus.sel_a;
  assign o_SelB       = ctl_bus.sel_b;
  assign o_WrAcc      = ctl_bus.wr_acc;
  assign o_Op         = ctl_bus.op;
  assign o_WrRam      = ctl_bus.wr_ram;
  assign o_RdRam      = ctl_bus.rd_ram;
  assign o_Halt       = (state_reg == HALT);
  assign o_InstrCount = count_reg;

endmodule

// File: tb/tb_bip_control.sv
// Directed testbench for bip_control: a per-cycle vector table for a short
// program plus hand-written sequences for enable stalls, PC wrap, reset
// during execute and NOP-then-halt.
module tb_bip_control;

  logic        clk;
  logic        i_reset;
  logic        i_enable;
  logic [15:0] i_Instruction;
  logic [10:0] o_Addr_PC;
  logic [10:0] o_Operand;
  logic        o_Halt;
  logic [15:0] o_InstrCount;

  logic [15:0] prog [0:2047];

  int vectors;
  int miscompares;

  bip_control_if tb_bus ();

  assign tb_bus.opcode = i_Instruction[15:11];
  assign tb_bus.exec   = i_enable;

  bip_control #(
    .NBITS_PC     (11),
    .NBITS_OPCODE (5),
    .NBITS_I      (16)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_Instruction (i_Instruction),
    .o_Addr_PC     (o_Addr_PC),
    .o_Operand     (o_Operand),
    .o_SelA        (tb_bus.sel_a),
    .o_SelB        (tb_bus.sel_b),
    .o_WrAcc       (tb_bus.wr_acc),
    .o_Op          (tb_bus.op),
    .o_WrRam       (tb_bus.wr_ram),
    .o_RdRam       (tb_bus.rd_ram),
    .o_Halt        (o_Halt),
    .o_InstrCount  (o_InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory with one cycle of read latency
  always @(posedge clk) i_Instruction <= prog[o_Addr_PC];

  typedef struct packed {
    logic        halt;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic [10:0] pc;
    logic [10:0] opd;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic en;
    obs_t exp;
  } row_t;

  function automatic row_t mk(input logic en, input logic halt, input logic wa,
                              input logic wr, input logic rd, input logic [1:0] sa,
                              input logic sb, input logic op, input logic [10:0] pc,
                              input logic [10:0] opd, input logic [15:0] cnt);
    row_t r;
    r.en         = en;
    r.exp.halt   = halt;
    r.exp.wr_acc = wa;
    r.exp.wr_ram = wr;
    r.exp.rd_ram = rd;
    r.exp.sel_a  = sa;
    r.exp.sel_b  = sb;
    r.exp.op     = op;
    r.exp.pc     = pc;
    r.exp.opd    = opd;
    r.exp.cnt    = cnt;
    return r;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("halt=%0b wa=%0b wr=%0b rd=%0b selA=%02b selB=%0b op=%0b pc=%03h opd=%03h cnt=%04h",
                     o.halt, o.wr_acc, o.wr_ram, o.rd_ram, o.sel_a, o.sel_b, o.op,
                     o.pc, o.opd, o.cnt);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.halt   = o_Halt;
    o.wr_acc = tb_bus.wr_acc;
    o.wr_ram = tb_bus.wr_ram;
    o.rd_ram = tb_bus.rd_ram;
    o.sel_a  = tb_bus.sel_a;
    o.sel_b  = tb_bus.sel_b;
    o.op     = tb_bus.op;
    o.pc     = o_Addr_PC;
    o.opd    = o_Operand;
    o.cnt    = o_InstrCount;
    return o;
  endfunction

  // Drive one cycle, compare mid-cycle, then advance to just after the edge
  task automatic apply(input string name, input row_t r);
    obs_t got;
    i_reset  = 1'b0;
    i_enable = r.en;
    #1;
    got = observe();
    vectors++;
    if (got !== r.exp) begin
      miscompares++;
      $display("FAIL %s: got %s required %s", name, fmt(got), fmt(r.exp));
    end else begin
      $display("ok   %s: %s", name, fmt(got));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic en, input logic rst);
    i_enable = en;
    i_reset  = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic fill_prog(input logic [15:0] word);
    for (int a = 0; a < 2048; a++) prog[a] = word;
  endtask

  row_t rows_a [16];

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b1;
    i_enable    = 1'b0;
    fill_prog(16'h0000);

    // LDI 5; ADDI 3; STO 2; HLT -- one row per cycle starting at IDLE
    rows_a[0]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0);
    rows_a[1]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0);
    rows_a[2]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0);
    rows_a[3]  = mk(1, 0, 1, 0, 0, 2'b01, 0, 0, 11'h000, 11'h005, 16'd0);
    rows_a[4]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h001, 11'h005, 16'd1);
    rows_a[5]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h001, 11'h005, 16'd1);
    rows_a[6]  = mk(1, 0, 1, 0, 0, 2'b10, 1, 0, 11'h001, 11'h003, 16'd1);
    rows_a[7]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h002, 11'h003, 16'd2);
    rows_a[8]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h002, 11'h003, 16'd2);
    rows_a[9]  = mk(1, 0, 0, 1, 0, 2'b00, 0, 0, 11'h002, 11'h002, 16'd2);
    rows_a[10] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h003, 11'h002, 16'd3);
    rows_a[11] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h003, 11'h002, 16'd3);
    rows_a[12] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h003, 11'h000, 16'd3);
    rows_a[13] = mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 11'h003, 11'h000, 16'd4);
    rows_a[14] = mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 11'h003, 11'h000, 16'd4);
    rows_a[15] = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 11'h003, 11'h000, 16'd4);

    prog[0] = 16'h1805;  // LDI 5
    prog[1] = 16'h2803;  // ADDI 3
    prog[2] = 16'h0802;  // STO 2
    prog[3] = 16'h0000;  // HLT
    do_reset();
    for (int i = 0; i < 16; i++) apply($sformatf("prog_a cyc%0d", i), rows_a[i]);

    // LD 7; SUB 8
    fill_prog(16'h0000);
    prog[0] = 16'h1007;
    prog[1] = 16'h3008;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0);
    apply("ld7 exec", mk(1, 0, 1, 0, 1, 2'b00, 0, 0, 11'h000, 11'h007, 16'd0));
    for (int i = 0; i < 2; i++) step(1, 0);
    apply("sub8 exec", mk(1, 0, 1, 0, 1, 2'b10, 0, 1, 11'h001, 11'h008, 16'd1));

    // Enable dropped for 4 cycles in DECODE, then for 1 cycle in EXEC
    fill_prog(16'h0000);
    prog[0] = 16'h1805;
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 0);
    for (int i = 0; i < 4; i++)
      apply($sformatf("stall decode %0d", i), mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0));
    apply("resume decode", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0));
    apply("stall exec", mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h005, 16'd0));
    apply("resume exec", mk(1, 0, 1, 0, 0, 2'b01, 0, 0, 11'h000, 11'h005, 16'd0));
    apply("after exec", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h001, 11'h005, 16'd1));

    // NOPs everywhere: run to the instruction at 0x7FF and watch the PC wrap
    fill_prog(16'h4000);
    do_reset();
    for (int i = 0; i < 1 + 3 * 2047; i++) step(1, 0);
    apply("nop7ff fetch", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h7FF, 11'h000, 16'd2047));
    apply("nop7ff decode", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h7FF, 11'h000, 16'd2047));
    apply("nop7ff exec", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h7FF, 11'h000, 16'd2047));
    apply("pc wrap", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd2048));

    // Reset during EXEC of ADDI: restart from IDLE with no strobe
    fill_prog(16'h0000);
    prog[0] = 16'h2803;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0);
    step(1, 1);
    apply("post reset idle", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0));
    step(1, 0);
    apply("post reset decode", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h000, 16'd0));
    apply("post reset exec", mk(1, 0, 1, 0, 0, 2'b10, 1, 0, 11'h000, 11'h003, 16'd0));

    // Opcode 11111 followed by HLT
    fill_prog(16'h0000);
    prog[0] = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0);
    apply("nop1f exec", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h000, 11'h7FF, 16'd0));
    for (int i = 0; i < 2; i++) step(1, 0);
    apply("hlt exec", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 11'h001, 11'h000, 16'd1));
    apply("halted", mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 11'h001, 11'h000, 16'd2));
    apply("halt sticky", mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 11'h001, 11'h000, 16'd2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
